// File: rtl/temp_pkg.sv
// Shared types and constants for the temperature scan controller and the display stage.
package temp_pkg;

    // Round sequencing states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DIV  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Result widths seen by the display/encode stage.
    localparam int RESULT_W = 16;
    localparam int COUNT_W  = 8;
    localparam int IDX_W    = 8;

    // Accumulator width that cannot overflow when every sensor reads full scale.
    function automatic int sum_width(input int temp_w, input int nr_sensors);
        return temp_w + $clog2(nr_sensors);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider: one quotient bit per cycle, DW cycles per divide.
// The first iteration is performed on the start cycle itself, so done pulses DW cycles
// after start and quotient/remainder are stable from that cycle on.
module seq_divider
    import temp_pkg::*;
#(
    parameter int DW = 11
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic [DW-1:0]      dividend_i,
    input  logic [COUNT_W-1:0] divisor_i,
    output logic               done_o,
    output logic [DW-1:0]      quotient_o,
    output logic [COUNT_W-1:0] remainder_o
);

    localparam int IW = $clog2(DW + 1);

    logic [DW-1:0]      quo_r;
    logic [COUNT_W-1:0] rem_r;
    logic [COUNT_W-1:0] div_r;
    logic [IW-1:0]      iter_r;
    logic               done_r;

    logic [DW-1:0]      src_quo_s;
    logic [COUNT_W-1:0] src_rem_s;
    logic [COUNT_W-1:0] src_div_s;
    logic [COUNT_W:0]   shifted_s;
    logic               fits_s;
    logic [DW-1:0]      nxt_quo_s;
    logic [COUNT_W-1:0] nxt_rem_s;

    // One restoring step, taking operands from the inputs on start and from state otherwise.
    always_comb begin
        src_quo_s = quo_r;
        src_rem_s = rem_r;
        src_div_s = div_r;
        if (start_i) begin
            src_quo_s = dividend_i;
            src_rem_s = {COUNT_W{1'b0}};
            src_div_s = divisor_i;
        end else begin
            src_quo_s = quo_r;
        end
        shifted_s = {src_rem_s, src_quo_s[DW-1]};
        fits_s    = (shifted_s >= {1'b0, src_div_s});
        if (fits_s) begin
            nxt_rem_s = COUNT_W'(shifted_s - {1'b0, src_div_s});
        end else begin
            nxt_rem_s = shifted_s[COUNT_W-1:0];
        end
        nxt_quo_s = {src_quo_s[DW-2:0], fits_s};
    end

    // Iteration state: load plus first step on start, then count down the remaining steps.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            quo_r  <= {DW{1'b0}};
            rem_r  <= {COUNT_W{1'b0}};
            div_r  <= {COUNT_W{1'b0}};
            iter_r <= {IW{1'b0}};
            done_r <= 1'b0;
        end else if (start_i) begin
            quo_r  <= nxt_quo_s;
            rem_r  <= nxt_rem_s;
            div_r  <= divisor_i;
            iter_r <= IW'(DW - 1);
            done_r <= 1'b0;
        end else if (iter_r != {IW{1'b0}}) begin
            quo_r  <= nxt_quo_s;
            rem_r  <= nxt_rem_s;
            iter_r <= iter_r - IW'(1);
            done_r <= (iter_r == IW'(1));
        end else begin
            done_r <= 1'b0;
        end
    end

    assign done_o      = done_r;
    assign quotient_o  = quo_r;
    assign remainder_o = rem_r;

endmodule

// File: rtl/temp_scan_controller.sv
// One temperature round: polls every sensor over req/ack, accumulates active readings,
// divides sum by active count and publishes the mean with a done pulse.
module temp_scan_controller
    import temp_pkg::*;
#(
    parameter int NR_SENSORS  = 8,
    parameter int TEMP_W      = 8,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                start_i,
    output logic                busy_o,
    output logic                sensor_req_o,
    output logic [IDX_W-1:0]    sensor_idx_o,
    input  logic                sensor_ack_i,
    input  logic                sensor_en_i,
    input  logic [TEMP_W-1:0]   sensor_temp_i,
    output logic [RESULT_W-1:0] temp_Q_o,
    output logic [RESULT_W-1:0] temp_R_o,
    output logic [COUNT_W-1:0]  active_sensors_nr_o,
    output logic                no_sensor_o,
    output logic                done_o
);

    localparam int SUM_W = sum_width(TEMP_W, NR_SENSORS);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_SENSORS - 1);
    // The wait cycle in which this count is held is the last one allowed for an ack.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_t              state_r;
    logic [SUM_W-1:0]    sum_r;
    logic [COUNT_W-1:0]  count_r;
    logic [IDX_W-1:0]    idx_r;
    logic [TMO_W-1:0]    tmo_r;
    logic                busy_r;
    logic                req_r;
    logic                done_r;
    logic                div_issued_r;
    logic [RESULT_W-1:0] q_r;
    logic [RESULT_W-1:0] r_r;
    logic [COUNT_W-1:0]  nr_r;
    logic                no_sensor_r;

    logic                div_start_s;
    logic                div_done_s;
    logic [SUM_W-1:0]    div_q_s;
    logic [COUNT_W-1:0]  div_r_s;

    // Kick the divider exactly once, on the first DIV cycle, when there is something to divide.
    assign div_start_s = (state_r == DIV) && !div_issued_r && (count_r != {COUNT_W{1'b0}});

    seq_divider #(
        .DW (SUM_W)
    ) u_divider (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .start_i     (div_start_s),
        .dividend_i  (sum_r),
        .divisor_i   (count_r),
        .done_o      (div_done_s),
        .quotient_o  (div_q_s),
        .remainder_o (div_r_s)
    );

    // Round FSM with the accumulator, sensor index, timeout counter and result registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r      <= IDLE;
            sum_r        <= {SUM_W{1'b0}};
            count_r      <= {COUNT_W{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            tmo_r        <= {TMO_W{1'b0}};
            busy_r       <= 1'b0;
            req_r        <= 1'b0;
            done_r       <= 1'b0;
            div_issued_r <= 1'b0;
            q_r          <= {RESULT_W{1'b0}};
            r_r          <= {RESULT_W{1'b0}};
            nr_r         <= {COUNT_W{1'b0}};
            no_sensor_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start_i) begin
                        sum_r        <= {SUM_W{1'b0}};
                        count_r      <= {COUNT_W{1'b0}};
                        idx_r        <= {IDX_W{1'b0}};
                        busy_r       <= 1'b1;
                        req_r        <= 1'b1;
                        div_issued_r <= 1'b0;
                        state_r      <= REQ;
                    end
                end
                REQ: begin
                    req_r   <= 1'b0;
                    tmo_r   <= {TMO_W{1'b0}};
                    state_r <= WAIT;
                end
                WAIT: begin
                    // An ack in the final allowed cycle still counts.
                    if (sensor_ack_i || (tmo_r == TMO_LAST)) begin
                        if (sensor_ack_i && sensor_en_i) begin
                            sum_r   <= sum_r + SUM_W'(sensor_temp_i);
                            count_r <= count_r + COUNT_W'(1);
                        end
                        if (idx_r == LAST_IDX) begin
                            state_r <= DIV;
                        end else begin
                            idx_r   <= idx_r + IDX_W'(1);
                            req_r   <= 1'b1;
                            state_r <= REQ;
                        end
                    end else begin
                        tmo_r <= tmo_r + TMO_W'(1);
                    end
                end
                DIV: begin
                    if (count_r == {COUNT_W{1'b0}}) begin
                        q_r         <= {RESULT_W{1'b0}};
                        r_r         <= {RESULT_W{1'b0}};
                        nr_r        <= {COUNT_W{1'b0}};
                        no_sensor_r <= 1'b1;
                        done_r      <= 1'b1;
                        state_r     <= DONE;
                    end else if (!div_issued_r) begin
                        div_issued_r <= 1'b1;
                    end else if (div_done_s) begin
                        q_r         <= RESULT_W'(div_q_s);
                        r_r         <= RESULT_W'(div_r_s);
                        nr_r        <= count_r;
                        no_sensor_r <= 1'b0;
                        done_r      <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    req_r   <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy_o              = busy_r;
    assign sensor_req_o        = req_r;
    assign sensor_idx_o        = idx_r;
    assign temp_Q_o            = q_r;
    assign temp_R_o            = r_r;
    assign active_sensors_nr_o = nr_r;
    assign no_sensor_o         = no_sensor_r;
    assign done_o              = done_r;

endmodule

// File: tb/tb_temp_scan_controller.sv
// Directed bench for temp_scan_controller: a sensor responder driven from cycle-level
// configuration tables, expected round results queued at start and checked at done_o.
module tb_temp_scan_controller;

    localparam int NR    = 8;
    localparam int TMO   = 15;
    localparam int SUM_W = 11;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic        busy_o;
    logic        sensor_req_o;
    logic [7:0]  sensor_idx_o;
    logic        sensor_ack_i = 1'b0;
    logic        sensor_en_i = 1'b0;
    logic [7:0]  sensor_temp_i = 8'd0;
    logic [15:0] temp_Q_o;
    logic [15:0] temp_R_o;
    logic [7:0]  active_sensors_nr_o;
    logic        no_sensor_o;
    logic        done_o;

    temp_scan_controller #(
        .NR_SENSORS  (NR),
        .TEMP_W      (8),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i               (clk_i),
        .rst_n_i             (rst_n_i),
        .start_i             (start_i),
        .busy_o              (busy_o),
        .sensor_req_o        (sensor_req_o),
        .sensor_idx_o        (sensor_idx_o),
        .sensor_ack_i        (sensor_ack_i),
        .sensor_en_i         (sensor_en_i),
        .sensor_temp_i       (sensor_temp_i),
        .temp_Q_o            (temp_Q_o),
        .temp_R_o            (temp_R_o),
        .active_sensors_nr_o (active_sensors_nr_o),
        .no_sensor_o         (no_sensor_o),
        .done_o              (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int q;
        int r;
        int nr;
        int nos;
        int lat;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    // Per-sensor behaviour: en flag, reading, ack delay in wait cycles (0 = never), late stray ack.
    int en_a[NR];
    int temp_a[NR];
    int dly_a[NR];
    int late_a[NR];

    // Results the bench expects to be on the outputs between done pulses.
    int last_q = 0;
    int last_r = 0;
    int last_nr = 0;
    int last_nos = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(output exp_t e);
        int sum;
        int c;
        int w;
        sum = 0; c = 0; e.lat = 0;
        for (int i = 0; i < NR; i++) begin
            w = (dly_a[i] >= 1 && dly_a[i] <= TMO) ? dly_a[i] : TMO;
            e.lat += 1 + w;
            if (dly_a[i] >= 1 && dly_a[i] <= TMO && en_a[i] != 0) begin
                sum += temp_a[i];
                c++;
            end
        end
        e.lat += (c != 0 ? SUM_W : 0) + 2;
        e.q   = (c != 0) ? sum / c : 0;
        e.r   = (c != 0) ? sum % c : 0;
        e.nr  = c;
        e.nos = (c == 0) ? 1 : 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_req"}, {31'd0, sensor_req_o}, 32'd0);
        check({tag, "_done"}, {31'd0, done_o}, 32'd0);
        check({tag, "_q"}, {16'd0, temp_Q_o}, 32'd0);
        check({tag, "_r"}, {16'd0, temp_R_o}, 32'd0);
        check({tag, "_nr"}, {24'd0, active_sensors_nr_o}, 32'd0);
        check({tag, "_nos"}, {31'd0, no_sensor_o}, 32'd0);
    endtask

    // One round: start, respond to each request from the tables, check results at done_o.
    task automatic run_round(input int hold_start, input int pulse_at, input int abort_idx);
        exp_t e;
        exp_t got;
        int cyc;
        int cnt;
        int cur;
        int nidx;
        int pending;
        int stray_at;
        int finished;
        int aborted;
        model(e);
        if (abort_idx < 0) sb.push_back(e);
        @(negedge clk_i);
        start_i = 1'b1;
        cyc = 0; cnt = 0; cur = 0; nidx = 0; pending = 0; stray_at = -1;
        finished = 0; aborted = 0;
        while (finished == 0 && cyc < 600) begin
            @(negedge clk_i);
            cyc++;
            start_i = (hold_start != 0) || (cyc == pulse_at);
            sensor_ack_i = 1'b0; sensor_en_i = 1'b0; sensor_temp_i = 8'd0;
            if (cyc == stray_at) begin
                sensor_ack_i = 1'b1; sensor_en_i = 1'b1; sensor_temp_i = 8'd200;
            end
            if (done_o) begin
                finished = 1;
            end else begin
                if (!busy_o) check("busy_in_round", {31'd0, busy_o}, 32'd1);
                if (pulse_at > 0 && cyc == pulse_at + 2) begin
                    check("held_q", {16'd0, temp_Q_o}, last_q);
                    check("held_r", {16'd0, temp_R_o}, last_r);
                    check("held_nr", {24'd0, active_sensors_nr_o}, last_nr);
                end
                if (sensor_req_o) begin
                    check("req_idx", {24'd0, sensor_idx_o}, nidx);
                    nidx++;
                    cur = (sensor_idx_o < 8'(NR)) ? int'(sensor_idx_o) : 0;
                    cnt = 0;
                    pending = 1;
                    if (late_a[cur] != 0) stray_at = cyc + TMO + 1;
                end else if (pending != 0) begin
                    cnt++;
                    if (abort_idx == cur) begin
                        rst_n_i = 1'b0;
                        #1;
                        check_outputs_zero("abort");
                        @(negedge clk_i);
                        rst_n_i = 1'b1;
                        aborted = 1;
                        finished = 1;
                    end else if (dly_a[cur] == cnt) begin
                        sensor_ack_i  = 1'b1;
                        sensor_en_i   = (en_a[cur] != 0);
                        sensor_temp_i = temp_a[cur][7:0];
                        pending = 0;
                    end else if (cnt == TMO) begin
                        pending = 0;
                    end
                end
            end
        end
        sensor_ack_i = 1'b0;
        check("round_finished", finished, 1);
        if (finished != 0 && aborted == 0) begin
            check("sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
            if (sb.size() > 0) begin
                got = sb.pop_front();
                check("latency", cyc, got.lat);
                check("temp_Q", {16'd0, temp_Q_o}, got.q);
                check("temp_R", {16'd0, temp_R_o}, got.r);
                check("active_nr", {24'd0, active_sensors_nr_o}, got.nr);
                check("no_sensor", {31'd0, no_sensor_o}, got.nos);
                last_q = got.q; last_r = got.r; last_nr = got.nr; last_nos = got.nos;
            end
            @(negedge clk_i);
            check("done_one_cycle", {31'd0, done_o}, 32'd0);
            check("busy_after_done", {31'd0, busy_o}, 32'd0);
            check("q_held_after_done", {16'd0, temp_Q_o}, last_q);
            if (hold_start != 0) begin
                @(negedge clk_i);
                check("restart_busy", {31'd0, busy_o}, 32'd1);
                check("restart_req", {31'd0, sensor_req_o}, 32'd1);
                check("restart_idx", {24'd0, sensor_idx_o}, 32'd0);
            end
        end else if (aborted != 0) begin
            last_q = 0; last_r = 0; last_nr = 0; last_nos = 0;
        end
        start_i = 1'b0;
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge clk_i);
        check_outputs_zero("reset");
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // All active, 20..27, immediate acks: 188/8 = 23 r 4.
        for (int i = 0; i < NR; i++) begin
            en_a[i] = 1; temp_a[i] = 20 + i; dly_a[i] = 1; late_a[i] = 0;
        end
        run_round(0, 0, -1);

        // Sensors 0 and 3 disabled, others read 18 with varied ack delays.
        for (int i = 0; i < NR; i++) begin
            en_a[i] = (i != 0 && i != 3) ? 1 : 0; temp_a[i] = 18; dly_a[i] = (i % 3) + 1; late_a[i] = 0;
        end
        run_round(0, 0, -1);

        // Sensor 5 silent then a late stray ack; a start pulse mid-round must be ignored.
        for (int i = 0; i < NR; i++) begin
            en_a[i] = 1; temp_a[i] = 30 + i; dly_a[i] = 2; late_a[i] = 0;
        end
        dly_a[5] = 0; late_a[5] = 1;
        run_round(0, 6, -1);

        // Ack exactly in the last allowed wait cycle still counts; sensor 7 times out.
        for (int i = 0; i < NR; i++) begin
            en_a[i] = 1; temp_a[i] = 100 + i; dly_a[i] = 1; late_a[i] = 0;
        end
        dly_a[2] = TMO; dly_a[7] = 0;
        run_round(0, 0, -1);

        // No active sensors: bypassed divider.
        for (int i = 0; i < NR; i++) begin
            en_a[i] = 0; temp_a[i] = 50; dly_a[i] = 1; late_a[i] = 0;
        end
        run_round(0, 0, -1);

        // Reset during the wait of sensor 4, then a clean full round.
        for (int i = 0; i < NR; i++) begin
            en_a[i] = 1; temp_a[i] = 20 + i; dly_a[i] = 1; late_a[i] = 0;
        end
        run_round(0, 0, 4);
        repeat (2) @(negedge clk_i);
        check_outputs_zero("post_abort");
        run_round(0, 0, -1);

        // Full-scale readings, start held high: next round begins right after busy falls.
        for (int i = 0; i < NR; i++) begin
            en_a[i] = 1; temp_a[i] = 255 - i; dly_a[i] = 3; late_a[i] = 0;
        end
        run_round(1, 0, -1);
        rst_n_i = 1'b0;
        #1;
        check_outputs_zero("final_reset");
        @(negedge clk_i);
        rst_n_i = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
